telem_rx: RTL
=============

Name: telem_rx

Overview:
- Bench and display-side receiver for the eBike telemetry stream driven on TX.
- Deserialises 8N1 UART bytes and locks onto the 0xAA 0x55 frame header.
- Reassembles the 12-bit batt, curr and torque readings and presents them as one atomic, validated snapshot.
- Sits directly downstream of the TX pin. Used in the full-chip testbench and in the handlebar display FPGA.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Minimum 8. Must match the transmitter.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  one clock; reset is synchronous and active-high
- RX  input  1  serial telemetry input, idle high, asynchronous to clk
- batt  output  12  last valid battery reading
- curr  output  12  last valid current reading
- torque  output  12  last valid torque reading
- vld  output  1  one-cycle pulse when batt/curr/torque update
- frm_err  output  1  one-cycle pulse on stop-bit error or malformed frame

Behaviour:
- Reset values: batt/curr/torque=12'h000, vld=0, frm_err=0, byte FSM=IDLE, frame FSM=HDR1, RX synchroniser flops=1.
- RX passes through a 2-flop synchroniser, preset to 1 on reset. All logic uses the synchronised RX.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge (synced RX 1->0) goes to START and clears the baud counter.
  - START: at count CLKS_PER_BIT/2 (floor), sample RX. If 0, go to DATA. If 1 (glitch), return to IDLE silently.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into a byte register.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, emit byte_rdy for one cycle. If 0, pulse frm_err, discard the byte, and force the frame FSM to HDR1. In both cases return to IDLE.
  - A new start edge is accepted in the cycle immediately after STOP.
- Frame FSM advances only on byte_rdy. States in order: HDR1, HDR2, BATT_H, BATT_L, CURR_H, CURR_L, TORQ_H, TORQ_L.
  - HDR1: 0xAA goes to HDR2. Any other byte stays in HDR1. No error is flagged; this is hunting, not a fault.
  - HDR2: 0x55 goes to BATT_H. 0xAA stays in HDR2. Any other byte returns to HDR1.
  - *_H states: the byte's upper nibble must be 0. Otherwise pulse frm_err and return to HDR1. The low nibble is held in a shadow register as bits [11:8].
  - *_L states: the byte is held in the shadow register as bits [7:0].
  - TORQ_L: copy all three shadow values to the outputs in the same cycle. vld asserts the cycle after the byte_rdy that completes TORQ_L. Return to HDR1.
- Outputs change only on that copy. A partial or aborted frame never disturbs batt/curr/torque.
- Latency: vld rises 2 clk after the stop-bit sample of the final byte.
- Simultaneous events: frm_err and vld are mutually exclusive by construction.
- Reset asserted mid-byte or mid-frame: all state returns to reset values on the next clk edge. Outputs clear to 0.
- Counter width: $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps.

Decomposition:
- Package telem_pkg holds:
  - the frame FSM enum frm_state_t
  - constants HDR_BYTE1=8'hAA, HDR_BYTE2=8'h55, FRAME_BYTES=8
  - the byte-FSM enum rx_state_t
- One sub-module, uart_rx_byte (clk, rst, RX, rx_data[7:0], rx_rdy, stop_err), containing the synchroniser, baud counter and byte FSM.
- telem_rx instantiates uart_rx_byte and holds the frame FSM plus the shadow and output registers.

Test Plan (bench uses CLKS_PER_BIT=16):
- Send AA 55 05 7A 01 23 0F FF. Expect batt=12'h57A, curr=12'h123, torque=12'hFFF, exactly one vld pulse, frm_err never set.
- Send garbage 13 AA AA 55, then 00 10 00 20 00 30. Expect resync, batt=0x010, curr=0x020, torque=0x030, one vld.
- Send a valid frame, then AA 55 F1 ... (upper nibble set). Expect frm_err pulse at the F1 byte, outputs unchanged, no vld.
- Drive a stop bit of 0 on the CURR_L byte. Expect frm_err. The next full frame updates the outputs normally.
- Drive a 4-cycle low glitch on idle RX. Expect no byte decoded, no frm_err, no vld.
- Assert rst for one cycle during the TORQ_H byte. Expect all outputs 0, no vld. A following clean frame decodes correctly.

Source files
------------

// File: rtl/telem_pkg.sv
// telem_pkg
//   Shared types and constants for the telemetry receiver: the frame header
//   bytes, the frame length, and the state types for the byte-level UART FSM
//   and the frame-level reassembly FSM.
package telem_pkg;

  localparam int unsigned FRAME_BYTES = 8;
  localparam logic [7:0]  HDR_BYTE1   = 8'hAA;
  localparam logic [7:0]  HDR_BYTE2   = 8'h55;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // One state per byte position in the frame.
  typedef enum logic [$clog2(FRAME_BYTES)-1:0] {
    FRM_HDR1,
    FRM_HDR2,
    FRM_BATT_H,
    FRM_BATT_L,
    FRM_CURR_H,
    FRM_CURR_L,
    FRM_TORQ_H,
    FRM_TORQ_L
  } frm_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver. Synchronises the asynchronous RX line, detects
//   the start edge, samples mid-bit using a baud counter and delivers each
//   byte with a one-cycle ready pulse, or a one-cycle stop error pulse when
//   the stop bit is low.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   RX        serial input, idle high, asynchronous to clk
//   rx_data   last received byte (valid while rx_rdy is high)
//   rx_rdy    one-cycle pulse: byte received with a good stop bit
//   stop_err  one-cycle pulse: stop bit sampled low, byte discarded
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a 1->0 edge on synchronised RX
// RX_START | counting to mid start bit to confirm it is still low
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit one bit period after the last data bit
module uart_rx_byte
  import telem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       stop_err
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             start_edge;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  assign start_edge = rx_prev & ~rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_rdy   <= 1'b0;
      stop_err <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end

        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            if (!rx_sync) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            rx_data <= {rx_sync, rx_data[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              rx_rdy <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/telem_rx.sv
// telem_rx
//   eBike telemetry receiver. Decodes UART bytes from RX, hunts for the
//   0xAA 0x55 header and reassembles the 12-bit battery, current and torque
//   readings into shadow registers. The outputs are updated together only
//   when a complete, well-formed frame has been received.
//
// Ports
//   clk      system clock
//   rst      synchronous active-high reset
//   RX       serial telemetry input, idle high, asynchronous to clk
//   batt     last valid battery reading
//   curr     last valid current reading
//   torque   last valid torque reading
//   vld      one-cycle pulse when batt/curr/torque update
//   frm_err  one-cycle pulse on stop-bit error or malformed frame
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FRM_HDR1   | hunting for 0xAA
// FRM_HDR2   | 0xAA seen, expecting 0x55 (repeated 0xAA keeps waiting)
// FRM_BATT_H | battery bits [11:8], upper nibble must be zero
// FRM_BATT_L | battery bits [7:0]
// FRM_CURR_H | current bits [11:8], upper nibble must be zero
// FRM_CURR_L | current bits [7:0]
// FRM_TORQ_H | torque bits [11:8], upper nibble must be zero
// FRM_TORQ_L | torque bits [7:0], then publish the snapshot
module telem_rx
  import telem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err
);

  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        stop_err;
  logic        nib_ok;
  frm_state_t  state;
  logic [11:0] batt_sh;
  logic [11:0] curr_sh;
  logic [3:0]  torq_hi;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .stop_err(stop_err)
  );

  assign nib_ok = (rx_data[7:4] == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FRM_HDR1;
      batt_sh <= '0;
      curr_sh <= '0;
      torq_hi <= '0;
      batt    <= '0;
      curr    <= '0;
      torque  <= '0;
      vld     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      vld     <= 1'b0;
      frm_err <= 1'b0;

      // stop_err and rx_rdy never coincide, so vld and frm_err cannot either.
      if (stop_err) begin
        frm_err <= 1'b1;
        state   <= FRM_HDR1;
      end else if (rx_rdy) begin
        case (state)
          FRM_HDR1: begin
            if (rx_data == HDR_BYTE1) state <= FRM_HDR2;
          end

          FRM_HDR2: begin
            if (rx_data == HDR_BYTE2) begin
              state <= FRM_BATT_H;
            end else if (rx_data != HDR_BYTE1) begin
              state <= FRM_HDR1;
            end
          end

          FRM_BATT_H: begin
            if (nib_ok) begin
              batt_sh[11:8] <= rx_data[3:0];
              state         <= FRM_BATT_L;
            end else begin
              frm_err <= 1'b1;
              state   <= FRM_HDR1;
            end
          end

          FRM_BATT_L: begin
            batt_sh[7:0] <= rx_data;
            state        <= FRM_CURR_H;
          end

          FRM_CURR_H: begin
            if (nib_ok) begin
              curr_sh[11:8] <= rx_data[3:0];
              state         <= FRM_CURR_L;
            end else begin
              frm_err <= 1'b1;
              state   <= FRM_HDR1;
            end
          end

          FRM_CURR_L: begin
            curr_sh[7:0] <= rx_data;
            state        <= FRM_TORQ_H;
          end

          FRM_TORQ_H: begin
            if (nib_ok) begin
              torq_hi <= rx_data[3:0];
              state   <= FRM_TORQ_L;
            end else begin
              frm_err <= 1'b1;
              state   <= FRM_HDR1;
            end
          end

          FRM_TORQ_L: begin
            // Torque low byte goes straight to the output so all three
            // readings land in the same cycle as vld.
            batt   <= batt_sh;
            curr   <= curr_sh;
            torque <= {torq_hi, rx_data};
            vld    <= 1'b1;
            state  <= FRM_HDR1;
          end

          default: state <= FRM_HDR1;
        endcase
      end
    end
  end

endmodule
